// File: rtl/connection_ctrl_arbiter_if.sv
// connection_ctrl_arbiter_if: signal bundle between the ctrl-channel arbiter, its requesters and the connection manager
//   s_req_*  requester -> arbiter request (valid/ready, packed ipAddr/udpPort/bind per requester)
//   m_rsp_*  arbiter -> requester response (one-hot valid, per-requester ready, shared fields)
//   m_cm_*   arbiter -> manager ctrl request;  s_cm_* manager -> arbiter ctrl response
//   timeout_count  saturating count of watchdog timeouts
//   modport slave = arbiter view, modport master = requesters + manager view
interface connection_ctrl_arbiter_if #(
    parameter int NREQ          = 2,
    parameter int CONN_ID_WIDTH = 12
);
    logic [NREQ-1:0]          s_req_valid;
    logic [NREQ*32-1:0]       s_req_ipAddr;
    logic [NREQ*16-1:0]       s_req_udpPort;
    logic [NREQ-1:0]          s_req_bind;
    logic [NREQ-1:0]          s_req_ready;
    logic [NREQ-1:0]          m_rsp_valid;
    logic [NREQ-1:0]          m_rsp_ready;
    logic                     m_rsp_ack;
    logic                     m_rsp_full;
    logic                     m_rsp_timeout;
    logic [CONN_ID_WIDTH-1:0] m_rsp_connectionId;
    logic                     m_cm_valid;
    logic                     m_cm_ready;
    logic [31:0]              m_cm_ipAddr;
    logic [15:0]              m_cm_udpPort;
    logic                     m_cm_bind;
    logic                     s_cm_valid;
    logic                     s_cm_ready;
    logic                     s_cm_ack;
    logic                     s_cm_full;
    logic [CONN_ID_WIDTH-1:0] s_cm_connectionId;
    logic [15:0]              timeout_count;

    modport slave (
        input  s_req_valid, s_req_ipAddr, s_req_udpPort, s_req_bind, m_rsp_ready,
               m_cm_ready, s_cm_valid, s_cm_ack, s_cm_full, s_cm_connectionId,
        output s_req_ready, m_rsp_valid, m_rsp_ack, m_rsp_full, m_rsp_timeout, m_rsp_connectionId,
               m_cm_valid, m_cm_ipAddr, m_cm_udpPort, m_cm_bind, s_cm_ready, timeout_count
    );

    modport master (
        output s_req_valid, s_req_ipAddr, s_req_udpPort, s_req_bind, m_rsp_ready,
               m_cm_ready, s_cm_valid, s_cm_ack, s_cm_full, s_cm_connectionId,
        input  s_req_ready, m_rsp_valid, m_rsp_ack, m_rsp_full, m_rsp_timeout, m_rsp_connectionId,
               m_cm_valid, m_cm_ipAddr, m_cm_udpPort, m_cm_bind, s_cm_ready, timeout_count
    );
endinterface

// File: rtl/connection_ctrl_arbiter.sv
// connection_ctrl_arbiter: round-robin sharing of the connection manager's bind/unbind channel with a response watchdog
//   s00_axis_ctrl_aclk     clock, rising edge
//   s00_axis_ctrl_aresetn  asynchronous active-low reset
//   bus                    requester / response / manager / status signals (slave view)
module connection_ctrl_arbiter #(
    parameter int NREQ           = 2,
    parameter int CONN_ID_WIDTH  = 12,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                      s00_axis_ctrl_aclk,
    input logic                      s00_axis_ctrl_aresetn,
    connection_ctrl_arbiter_if.slave bus
);
    localparam int GW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                   state, state_n;
    logic [GW-1:0]            grant, last_grant, winner, cand;
    logic                     found;
    logic [TW-1:0]            timer;
    logic                     stale;
    logic [31:0]              ip;
    logic [15:0]              port;
    logic                     bind_q;
    logic                     ack, full, tmo;
    logic [CONN_ID_WIDTH-1:0] id;
    logic [15:0]              tcount;
    logic                     accept, issued, rsp_take, expire, rsp_done;

    // Scan downward so the candidate closest after last_grant is assigned last and wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = GW'((int'(last_grant) + i) % NREQ);
            if (bus.s_req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Gating with the reset keeps s_req_ready low while held in reset.
    assign accept   = s00_axis_ctrl_aresetn && state == IDLE && found;
    assign issued   = state == ISSUE && bus.m_cm_ready;
    assign rsp_take = state == WAIT && bus.s_cm_valid && !stale;
    assign expire   = state == WAIT && !rsp_take && timer == TW'(TIMEOUT_CYCLES - 1);
    assign rsp_done = state == RESP && bus.m_rsp_ready[grant];

    always_ff @(posedge s00_axis_ctrl_aclk or negedge s00_axis_ctrl_aresetn) begin
        if (!s00_axis_ctrl_aresetn) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n                = accept ? ISSUE :
                                 issued ? WAIT :
                                 (rsp_take || expire) ? RESP :
                                 rsp_done ? IDLE : state;
        bus.s_req_ready        = '0;
        bus.s_req_ready[winner] = accept;
        bus.m_rsp_valid        = '0;
        bus.m_rsp_valid[grant] = state == RESP;
        bus.m_cm_valid         = state == ISSUE;
        bus.s_cm_ready         = s00_axis_ctrl_aresetn;
    end

    always_ff @(posedge s00_axis_ctrl_aclk or negedge s00_axis_ctrl_aresetn) begin
        if (!s00_axis_ctrl_aresetn) begin
            grant      <= '0;
            last_grant <= GW'(NREQ - 1);
            ip         <= '0;
            port       <= '0;
            bind_q     <= 1'b0;
            timer      <= '0;
            stale      <= 1'b0;
            ack        <= 1'b0;
            full       <= 1'b0;
            tmo        <= 1'b0;
            id         <= '0;
            tcount     <= '0;
        end else begin
            if (accept) begin
                grant  <= winner;
                ip     <= bus.s_req_ipAddr[32*int'(winner) +: 32];
                port   <= bus.s_req_udpPort[16*int'(winner) +: 16];
                bind_q <= bus.s_req_bind[winner];
            end
            // A dropped stale response freezes the timer for that cycle.
            if (issued) timer <= '0;
            else if (state == WAIT && !(bus.s_cm_valid && stale)) timer <= timer + 1'b1;
            // After a timeout the manager may still answer late; that answer must be discarded.
            if (expire) stale <= 1'b1;
            else if (bus.s_cm_valid) stale <= 1'b0;
            if (rsp_take) begin
                ack  <= bus.s_cm_ack;
                full <= bus.s_cm_full;
                tmo  <= 1'b0;
                id   <= bus.s_cm_connectionId;
            end
            if (expire) begin
                ack  <= 1'b0;
                full <= 1'b0;
                tmo  <= 1'b1;
                id   <= '0;
                if (tcount != 16'hFFFF) tcount <= tcount + 1'b1;
            end
            if (rsp_done) last_grant <= grant;
        end
    end

    assign bus.m_cm_ipAddr        = ip;
    assign bus.m_cm_udpPort       = port;
    assign bus.m_cm_bind          = bind_q;
    assign bus.m_rsp_ack          = ack;
    assign bus.m_rsp_full         = full;
    assign bus.m_rsp_timeout      = tmo;
    assign bus.m_rsp_connectionId = id;
    assign bus.timeout_count      = tcount;
endmodule
